// File: rtl/cpu_queue_reg_arbiter.sv
// Routes one CPU register channel to NUM_QUEUES per-queue register blocks by address index,
// holding the selected request until that block acks or TIMEOUT expires. Latency 3 cycles with a 1-cycle-ack downstream.
module cpu_queue_reg_arbiter #(
  parameter int NUM_QUEUES  = 4,
  parameter int IDX_WIDTH   = 2,
  parameter int QADDR_WIDTH = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             reg_req,
  input  logic                             reg_rd_wr_L,
  input  logic [IDX_WIDTH+QADDR_WIDTH-1:0] reg_addr,
  input  logic [DATA_WIDTH-1:0]            reg_wr_data,
  output logic [DATA_WIDTH-1:0]            reg_rd_data,
  output logic                             reg_ack,
  output logic                             reg_err,
  output logic [NUM_QUEUES-1:0]            q_reg_req,
  output logic                             q_reg_rd_wr_L,
  output logic [QADDR_WIDTH-1:0]           q_reg_addr,
  output logic [DATA_WIDTH-1:0]            q_reg_wr_data,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] q_reg_rd_data,
  input  logic [NUM_QUEUES-1:0]            q_reg_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] BAD_DATA = DATA_WIDTH'(32'hdead_beef);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_ERR,
    S_TERR
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    reg_req_d1_q;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [NUM_QUEUES-1:0]   q_reg_req_q, q_reg_req_d;
  logic                    q_reg_rd_wr_L_q, q_reg_rd_wr_L_d;
  logic [QADDR_WIDTH-1:0]  q_reg_addr_q, q_reg_addr_d;
  logic [DATA_WIDTH-1:0]   q_reg_wr_data_q, q_reg_wr_data_d;
  logic [DATA_WIDTH-1:0]   reg_rd_data_q, reg_rd_data_d;
  logic                    reg_ack_q, reg_ack_d;
  logic                    reg_err_q, reg_err_d;

  logic                    new_req;
  logic [IDX_WIDTH-1:0]    req_idx;
  logic                    idx_valid;
  logic [NUM_QUEUES-1:0]   req_onehot;
  logic                    sel_ack;
  logic [DATA_WIDTH-1:0]   sel_data;

  assign new_req   = reg_req && !reg_req_d1_q;
  assign req_idx   = reg_addr[QADDR_WIDTH +: IDX_WIDTH];
  assign idx_valid = int'(req_idx) < NUM_QUEUES;

  // Selection by comparison keeps indices in range when NUM_QUEUES < 2**IDX_WIDTH.
  always_comb begin
    req_onehot = '0;
    sel_ack    = 1'b0;
    sel_data   = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (req_idx == IDX_WIDTH'(i)) req_onehot[i] = 1'b1;
      if (idx_q == IDX_WIDTH'(i)) begin
        sel_ack  = q_reg_ack[i];
        sel_data = q_reg_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    q_reg_req_d     = q_reg_req_q;
    q_reg_rd_wr_L_d = q_reg_rd_wr_L_q;
    q_reg_addr_d    = q_reg_addr_q;
    q_reg_wr_data_d = q_reg_wr_data_q;
    reg_rd_data_d   = reg_rd_data_q;
    reg_ack_d       = 1'b0;
    reg_err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (new_req) begin
          idx_d           = req_idx;
          q_reg_rd_wr_L_d = reg_rd_wr_L;
          q_reg_addr_d    = reg_addr[QADDR_WIDTH-1:0];
          q_reg_wr_data_d = reg_wr_data;
          if (!idx_valid) begin
            state_d       = S_ERR;
            reg_ack_d     = 1'b1;
            reg_err_d     = 1'b1;
            reg_rd_data_d = BAD_DATA;
          end else begin
            state_d     = S_REQ;
            q_reg_req_d = req_onehot;
            cnt_d       = '0;
          end
        end
      end
      S_REQ: begin
        // An ack on the final timeout cycle still counts as success.
        if (sel_ack) begin
          state_d       = S_DONE;
          q_reg_req_d   = '0;
          reg_rd_data_d = sel_data;
          reg_ack_d     = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d       = S_TERR;
          q_reg_req_d   = '0;
          reg_rd_data_d = BAD_DATA;
          reg_ack_d     = 1'b1;
          reg_err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE, S_ERR, S_TERR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // reg_req_d1 tracks through reset so a held request is not replayed afterwards.
    reg_req_d1_q <= reg_req;
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      q_reg_req_q     <= '0;
      q_reg_rd_wr_L_q <= 1'b0;
      q_reg_addr_q    <= '0;
      q_reg_wr_data_q <= '0;
      reg_rd_data_q   <= '0;
      reg_ack_q       <= 1'b0;
      reg_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      q_reg_req_q     <= q_reg_req_d;
      q_reg_rd_wr_L_q <= q_reg_rd_wr_L_d;
      q_reg_addr_q    <= q_reg_addr_d;
      q_reg_wr_data_q <= q_reg_wr_data_d;
      reg_rd_data_q   <= reg_rd_data_d;
      reg_ack_q       <= reg_ack_d;
      reg_err_q       <= reg_err_d;
    end
  end

  assign reg_rd_data   = reg_rd_data_q;
  assign reg_ack       = reg_ack_q;
  assign reg_err       = reg_err_q;
  assign q_reg_req     = q_reg_req_q;
  assign q_reg_rd_wr_L = q_reg_rd_wr_L_q;
  assign q_reg_addr    = q_reg_addr_q;
  assign q_reg_wr_data = q_reg_wr_data_q;

endmodule
